// File: rtl/puf_challenge_driver.sv
`default_nettype none
// ============================================================================
//  Module   : puf_challenge_driver
//  Purpose  : Drives a delay-based PUF unit. Each accepted start runs a batch
//             of RESP_W excitations. Every bit has three phases:
//               FIRE    (SETTLE cycles)
//               SAMPLE  (1 cycle)
//               RELEASE (SETTLE cycles)
//             The challenge comes from a 64-bit Fibonacci LFSR that advances
//             once per bit. The synchronized response bits are collected
//             MSB-first and returned through a valid/ready handshake.
//  Ports    : clk, rst_n        - clock, async active-low reset
//             i_start           - batch request (IDLE only)
//             i_seed            - LFSR seed (zero is replaced by all-ones)
//             i_tune_init       - initial tune value
//             o_puf_in          - excitation edge to PUF unit
//             o_challenge       - challenge vector (LFSR state)
//             o_tune            - tune vector
//             i_puf_out         - PUF response (asynchronous to clk)
//             o_busy            - batch in progress
//             o_resp_word       - collected response bits, first bit in MSB
//             o_resp_ones       - count of ones in o_resp_word
//             o_resp_valid      - response valid
//             i_resp_ready      - response accepted
//  Config   : `define PUF_TUNE_ADAPT_EN
//             Enables tune adaptation at each response handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module puf_challenge_driver #(
    parameter int N_CB   = 64,
    parameter int N      = 16,
    parameter int RESP_W = 32,
    parameter int SETTLE = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_start,
    input  logic [N_CB-1:0]              i_seed,
    input  logic [N-1:0]                 i_tune_init,
    output logic                         o_puf_in,
    output logic [N_CB-1:0]              o_challenge,
    output logic [N-1:0]                 o_tune,
    input  logic                         i_puf_out,
    output logic                         o_busy,
    output logic [RESP_W-1:0]            o_resp_word,
    output logic [$clog2(RESP_W+1)-1:0]  o_resp_ones,
    output logic                         o_resp_valid,
    input  logic                         i_resp_ready
);

    localparam int            c_OW        = $clog2(RESP_W + 1);
    localparam logic [7:0]    c_SETTLE_M1 = 8'(SETTLE - 1);
    localparam logic [c_OW-1:0] c_RESP_W  = c_OW'(RESP_W);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FIRE    = 3'd1,
        SAMPLE  = 3'd2,
        RELEASE = 3'd3,
        VALID   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [7:0]        r_cnt;
    logic [c_OW-1:0]   r_bits;
    logic [N_CB-1:0]   r_lfsr;
    logic [RESP_W-1:0] r_word;
    logic [c_OW-1:0]   r_ones;
    logic              r_valid;
    logic [N-1:0]      r_tune;
    logic              r_sync1;
    logic              r_sync2;

    logic              w_accept;
    logic              w_hs;
    logic              w_phase_done;
    logic              w_fb;

    assign w_accept     = (r_state == IDLE) && i_start;
    assign w_hs         = (r_state == VALID) && r_valid && i_resp_ready;
    assign w_phase_done = (r_cnt == c_SETTLE_M1);
    // Taps 64,63,61,60 (1-based) feeding bit 0; the register shifts toward the MSB.
    assign w_fb         = r_lfsr[63] ^ r_lfsr[62] ^ r_lfsr[60] ^ r_lfsr[59];

    // Two-flop synchronizer for the asynchronous PUF response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_puf_out;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_start)      w_state_next = FIRE;
            FIRE:    if (w_phase_done) w_state_next = SAMPLE;
            SAMPLE:                    w_state_next = RELEASE;
            RELEASE: if (w_phase_done) w_state_next = (r_bits == c_RESP_W) ? VALID : FIRE;
            VALID:   if (w_hs)         w_state_next = IDLE;
            default:                   w_state_next = IDLE;
        endcase
    end

    // Phase counter: runs only inside FIRE/RELEASE and restarts on every phase change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (((r_state == FIRE) || (r_state == RELEASE)) && !w_phase_done) begin
            r_cnt <= r_cnt + 8'd1;
        end else begin
            r_cnt <= 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr  <= '0;
            r_word  <= '0;
            r_ones  <= '0;
            r_bits  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_lfsr <= (i_seed == '0) ? '1 : i_seed;
                r_word <= '0;
                r_ones <= '0;
                r_bits <= '0;
            end else if (r_state == SAMPLE) begin
                r_word <= {r_word[RESP_W-2:0], r_sync2};
                r_ones <= r_ones + {{(c_OW-1){1'b0}}, r_sync2};
                r_bits <= r_bits + {{(c_OW-1){1'b0}}, 1'b1};
                // Advancing here makes the new challenge visible on the first RELEASE cycle.
                r_lfsr <= {r_lfsr[N_CB-2:0], w_fb};
            end
            // Valid is asserted one cycle after VALID is entered. This extra cycle
            // sets the start-to-valid latency to 1 + RESP_W*(2*SETTLE+1).
            r_valid <= (r_state == VALID) && !w_hs;
        end
    end

`ifdef PUF_TUNE_ADAPT_EN
    localparam logic [c_OW-1:0] c_HALF = c_OW'(RESP_W / 2);
    logic r_tune_loaded;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tune        <= '0;
            r_tune_loaded <= 1'b0;
        end else if (w_accept && !r_tune_loaded) begin
            r_tune        <= i_tune_init;
            r_tune_loaded <= 1'b1;
        end else if (w_hs) begin
            if ((r_ones > c_HALF) && (r_tune != '0)) begin
                r_tune <= r_tune - {{(N-1){1'b0}}, 1'b1};
            end else if ((r_ones < c_HALF) && (r_tune != '1)) begin
                r_tune <= r_tune + {{(N-1){1'b0}}, 1'b1};
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_tune <= '0;
        else if (w_accept) r_tune <= i_tune_init;
    end
`endif

    assign o_puf_in     = (r_state == FIRE) || (r_state == SAMPLE);
    assign o_busy       = (r_state != IDLE);
    assign o_challenge  = r_lfsr;
    assign o_tune       = r_tune;
    assign o_resp_word  = r_word;
    assign o_resp_ones  = r_ones;
    assign o_resp_valid = r_valid;

endmodule
`default_nettype wire

// File: doc/puf_challenge_driver.md
PUF_CHALLENGE_DRIVER -- requirements
Module: puf_challenge_driver

Interface
REQ-001 Parameter N_CB, default 64: challenge width; only 64 supported (LFSR taps fixed).
REQ-002 Parameter N, default 16: tune width.
REQ-003 Parameter RESP_W, default 32: response bits collected per batch.
REQ-004 Parameter SETTLE, default 8, legal range 4..255: cycles per fire phase and per release phase.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  request one batch; sampled in IDLE only.
REQ-008 seed  in  N_CB  LFSR seed, captured on accepted start.
REQ-009 tune_init  in  N  initial tune value.
REQ-010 puf_in  out  1  excitation edge to PUF unit.
REQ-011 challenge  out  N_CB  challenge vector to PUF unit.
REQ-012 tune  out  N  tune vector to PUF unit.
REQ-013 puf_out  in  1  PUF unit response; asynchronous to clk.
REQ-014 busy  out  1  high from accepted start until response handshake completes.
REQ-015 resp_word  out  RESP_W  collected bits; first bit in MSB.
REQ-016 resp_ones  out  clog2(RESP_W+1)  count of ones in resp_word.
REQ-017 resp_valid  out  1  resp_word/resp_ones valid.
REQ-018 resp_ready  in  1  consumer accepts response.

Function
REQ-019 puf_out SHALL pass a two-flop synchronizer; only the synchronized value is used.
REQ-020 FSM states SHALL be IDLE, FIRE, SAMPLE, RELEASE, VALID.
REQ-021 IDLE: start=1 -> capture seed (zero seed replaced by all-ones), clear resp_word/bit counter, busy=1, next state FIRE.
REQ-022 FIRE: puf_in=1 for SETTLE cycles, then SAMPLE.
REQ-023 SAMPLE: one cycle, puf_in=1; shift synchronized puf_out into resp_word LSB (shift left); increment resp_ones if 1; then RELEASE.
REQ-024 RELEASE: puf_in=0 for SETTLE cycles; LFSR advances once on entry; after RESP_W-th bit go to VALID, else FIRE.
REQ-025 challenge SHALL equal LFSR state; LFSR is Fibonacci, taps 64,63,61,60, shift toward MSB, feedback into bit 0.
REQ-026 Per-bit period SHALL be 2*SETTLE+1 cycles; resp_valid rises exactly 1 + RESP_W*(2*SETTLE+1) cycles after the start-accept edge.
REQ-027 VALID: resp_valid=1, resp_word/resp_ones stable until resp_valid&resp_ready; then IDLE, busy=0 next cycle.
REQ-028 start while busy=1 SHALL be ignored; start in the handshake cycle SHALL be ignored.
REQ-029 puf_in SHALL be 0 in IDLE and VALID.
REQ-030 Without tune adaptation, tune SHALL load tune_init on every accepted start and hold.

Reset
REQ-031 rst_n=0 SHALL immediately force: state IDLE, puf_in=0, busy=0, resp_valid=0, resp_word=0, resp_ones=0, challenge=0, tune=0, synchronizer flops=0.
REQ-032 Reset mid-batch SHALL discard partial response; first start after release begins a fresh batch.

Configuration
REQ-033 Macro PUF_TUNE_ADAPT_EN defined: tune loads tune_init only on first accepted start after reset; at each response handshake, resp_ones > RESP_W/2 -> tune-1 (saturate at 0), < RESP_W/2 -> tune+1 (saturate at all-ones), equal -> hold.
REQ-034 Macro PUF_TUNE_ADAPT_EN undefined: REQ-030 applies; no adaptation logic present.

Verification
REQ-035 seed=0x1, SETTLE=8, puf_out tied 1, start pulse -> resp_valid at cycle 545, resp_word=0xFFFFFFFF, resp_ones=32; challenge sequence matches LFSR model.
REQ-036 seed=0 -> first challenge=0xFFFFFFFFFFFFFFFF.
REQ-037 puf_out toggled per sample starting at 1 -> resp_word=0xAAAAAAAA, resp_ones=16; resp_ready held 0 for 10 cycles -> outputs stable, busy=1.
REQ-038 start pulsed during FIRE of bit 5 -> ignored, batch completes normally.
REQ-039 rst_n=0 during RELEASE of bit 12 -> puf_in=0, busy=0 same cycle; restart yields full 32-bit batch.
REQ-040 PUF_TUNE_ADAPT_EN, tune_init=0x8000, puf_out=1 -> tune=0x7FFF after batch 1, 0x7FFE after batch 2; tune_init=0 with puf_out=1 -> tune stays 0.
